// File: rtl/tuple_dispatch_sched.sv
// Round-robin scheduler: drains NUM_QUEUES fall-through tuple/len FIFOs into a valid/ready descriptor port.
// Define SCHED_SHAPER_EN to add a token-bucket byte-rate shaper in front of the grant.
module tuple_dispatch_sched #(
  parameter int NUM_QUEUES      = 4,
  parameter int PKT_TUPLE_WIDTH = 104,
  parameter int PKT_LEN_WIDTH   = 16,
  parameter int TOKEN_WIDTH     = 24,
  parameter int QW              = $clog2(NUM_QUEUES)
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [NUM_QUEUES*(PKT_TUPLE_WIDTH+PKT_LEN_WIDTH)-1:0] q_data,
  input  logic [NUM_QUEUES-1:0]                               q_empty,
  output logic [NUM_QUEUES-1:0]                               q_rd_en,
  output logic [PKT_TUPLE_WIDTH-1:0]                          out_tuple,
  output logic [PKT_LEN_WIDTH-1:0]                            out_pkt_len,
  output logic [QW-1:0]                                       out_qid,
  output logic                                                out_vld,
  input  logic                                                out_ready,
  input  logic                                                cfg_enable,
  input  logic [15:0]                                         cfg_tick_div,
  input  logic [TOKEN_WIDTH-1:0]                              cfg_tokens_per_tick,
  input  logic [TOKEN_WIDTH-1:0]                              cfg_bucket_max,
  output logic [31:0]                                         pkt_count
);

  localparam int EW = PKT_TUPLE_WIDTH + PKT_LEN_WIDTH;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                     state_q;
  logic [QW-1:0]              rr_ptr_q;
  logic [PKT_TUPLE_WIDTH-1:0] out_tuple_q;
  logic [PKT_LEN_WIDTH-1:0]   out_len_q;
  logic [QW-1:0]              out_qid_q;
  logic                       out_vld_q;
  logic [31:0]                pkt_count_q;

  logic [PKT_TUPLE_WIDTH-1:0] q_tuple [NUM_QUEUES];
  logic [PKT_LEN_WIDTH-1:0]   q_len   [NUM_QUEUES];

  logic [QW-1:0] cand_idx;
  logic [QW-1:0] scan_idx;
  logic          cand_found;
  logic          eligible;
  logic          grant;

  for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_queue
    assign q_len[gi]   = q_data[gi*EW +: PKT_LEN_WIDTH];
    assign q_tuple[gi] = q_data[gi*EW + PKT_LEN_WIDTH +: PKT_TUPLE_WIDTH];
    assign q_rd_en[gi] = grant && (cand_idx == QW'(gi));
  end

  // First nonempty queue strictly after the last served one, wrapping.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    scan_idx   = '0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      scan_idx = QW'((int'(rr_ptr_q) + k) % NUM_QUEUES);
      if (!cand_found && !q_empty[scan_idx]) begin
        cand_found = 1'b1;
        cand_idx   = scan_idx;
      end
    end
  end

  // Reset is folded in so no pop can escape while the block is held in reset.
  assign grant = !reset && (state_q == IDLE) && cfg_enable && cand_found && eligible;

`ifdef SCHED_SHAPER_EN
  logic [PKT_LEN_WIDTH-1:0] cand_len;
  logic [TOKEN_WIDTH-1:0]   tokens_q, tokens_d;
  logic [15:0]              tick_q, tick_d;
  logic                     refill;
  logic [TOKEN_WIDTH:0]     len_ext;
  logic [TOKEN_WIDTH:0]     tok_sum;

  assign cand_len = q_len[cand_idx];
  assign len_ext  = (TOKEN_WIDTH+1)'(cand_len);
  assign eligible = {1'b0, tokens_q} >= len_ext;

  // >= rather than == so a lowered divider cannot strand the counter above it.
  assign refill = tick_q >= cfg_tick_div;
  assign tick_d = refill ? 16'd0 : tick_q + 16'd1;

  always_comb begin
    tok_sum = {1'b0, tokens_q}
            + (refill ? {1'b0, cfg_tokens_per_tick} : '0)
            - (grant ? len_ext : '0);
    if (tok_sum > {1'b0, cfg_bucket_max}) begin
      tokens_d = cfg_bucket_max;
    end else begin
      tokens_d = tok_sum[TOKEN_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tokens_q <= '0;
      tick_q   <= '0;
    end else begin
      tokens_q <= tokens_d;
      tick_q   <= tick_d;
    end
  end
`else
  logic unused_cfg;

  assign eligible   = 1'b1;
  assign unused_cfg = ^{cfg_tick_div, cfg_tokens_per_tick, cfg_bucket_max};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= QW'(NUM_QUEUES - 1);
      out_tuple_q <= '0;
      out_len_q   <= '0;
      out_qid_q   <= '0;
      out_vld_q   <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            out_tuple_q <= q_tuple[cand_idx];
            out_len_q   <= q_len[cand_idx];
            out_qid_q   <= cand_idx;
            rr_ptr_q    <= cand_idx;
            out_vld_q   <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            out_vld_q   <= 1'b0;
            pkt_count_q <= pkt_count_q + 32'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_tuple   = out_tuple_q;
  assign out_pkt_len = out_len_q;
  assign out_qid     = out_qid_q;
  assign out_vld     = out_vld_q;
  assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_tuple_dispatch_sched.sv
// Bench for tuple_dispatch_sched: queue-level reference model checked every cycle plus literal expectations.
// Shaper scenarios are compiled only when SCHED_SHAPER_EN is defined.
`timescale 1ns/1ps
module tb_tuple_dispatch_sched;
  localparam int NQ = 4;
  localparam int TW = 104;
  localparam int LW = 16;
  localparam int KW = 24;
  localparam int QW = 2;
  localparam int EW = TW + LW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NQ*EW-1:0]  q_data;
  logic [NQ-1:0]     q_empty;
  logic [NQ-1:0]     q_rd_en;
  logic [TW-1:0]     out_tuple;
  logic [LW-1:0]     out_pkt_len;
  logic [QW-1:0]     out_qid;
  logic              out_vld;
  logic              out_ready;
  logic              cfg_enable;
  logic [15:0]       cfg_tick_div;
  logic [KW-1:0]     cfg_tokens_per_tick;
  logic [KW-1:0]     cfg_bucket_max;
  logic [31:0]       pkt_count;

  always #5 clk = ~clk;

  tuple_dispatch_sched #(
    .NUM_QUEUES(NQ), .PKT_TUPLE_WIDTH(TW), .PKT_LEN_WIDTH(LW), .TOKEN_WIDTH(KW)
  ) dut (
    .clk(clk), .reset(reset), .q_data(q_data), .q_empty(q_empty), .q_rd_en(q_rd_en),
    .out_tuple(out_tuple), .out_pkt_len(out_pkt_len), .out_qid(out_qid), .out_vld(out_vld),
    .out_ready(out_ready), .cfg_enable(cfg_enable), .cfg_tick_div(cfg_tick_div),
    .cfg_tokens_per_tick(cfg_tokens_per_tick), .cfg_bucket_max(cfg_bucket_max),
    .pkt_count(pkt_count)
  );

  logic [EW-1:0] fifo [NQ][$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit            m_busy;
  int            m_last;
  int            m_count;
  logic [TW-1:0] m_tuple;
  logic [LW-1:0] m_len;
  int            m_qid;
  longint        m_tokens;
  int            cyc;
  logic [NQ-1:0] rd_sample = '0;

  int pop_cnt [NQ];
  int acc_qid [$];
  int acc_cyc [$];
  int grant_cyc [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void refresh();
    for (int i = 0; i < NQ; i++) begin
      if (fifo[i].size() > 0) begin
        q_data[i*EW +: EW] = fifo[i][0];
        q_empty[i] = 1'b0;
      end else begin
        q_data[i*EW +: EW] = '0;
        q_empty[i] = 1'b1;
      end
    end
  endfunction

  task automatic push(input int q, input logic [TW-1:0] tuple, input logic [LW-1:0] len);
    fifo[q].push_back({tuple, len});
    refresh();
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(input int max);
    int t = 0;
    while (out_vld !== 1'b1 && t < max) begin
      @(negedge clk);
      t++;
    end
    chk("wait_vld", out_vld, 1);
  endtask

  task automatic wait_acc(input int n, input int max);
    int t = 0;
    while (acc_qid.size() < n && t < max) begin
      @(negedge clk);
      t++;
    end
    chk("wait_acc", acc_qid.size(), n);
  endtask

  task automatic wait_grants(input int n, input int max);
    int t = 0;
    while (grant_cyc.size() < n && t < max) begin
      @(negedge clk);
      t++;
    end
    chk("wait_grants", grant_cyc.size(), n);
  endtask

  // FIFO side: pop whatever the DUT strobed during the cycle that just ended.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NQ; i++) begin
      if (rd_sample[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
    end
    refresh();
  end

  // Compare process: DUT outputs versus the model, then advance the model one cycle.
  always @(negedge clk) begin
    int            exp_pop;
    logic [NQ-1:0] exp_rd;
    logic [EW-1:0] head;
    bit            refill;
    if (reset) begin
      chk("rst_vld", out_vld, 0);
      chk("rst_rd_en", q_rd_en, 0);
      chk("rst_count", pkt_count, 0);
      chk("rst_qid", out_qid, 0);
      chk("rst_desc", {out_tuple, out_pkt_len}, 0);
      m_busy = 0; m_last = NQ - 1; m_count = 0; m_tuple = '0; m_len = '0; m_qid = 0;
      m_tokens = 0; cyc = 0; rd_sample = '0;
    end else begin
      exp_pop = -1;
      head = '0;
      if (!m_busy && cfg_enable) begin
        for (int k = 1; k <= NQ; k++) begin
          if (exp_pop < 0 && fifo[(m_last + k) % NQ].size() > 0) exp_pop = (m_last + k) % NQ;
        end
      end
      if (exp_pop >= 0) head = fifo[exp_pop][0];
`ifdef SCHED_SHAPER_EN
      if (exp_pop >= 0 && m_tokens < longint'(head[LW-1:0])) exp_pop = -1;
`endif
      exp_rd = (exp_pop >= 0) ? (NQ'(1) << exp_pop) : '0;
      chk("q_rd_en", q_rd_en, exp_rd);
      chk("out_vld", out_vld, m_busy);
      chk("out_desc", {out_tuple, out_pkt_len, out_qid}, {m_tuple, m_len, QW'(m_qid)});
      chk("pkt_count", pkt_count, m_count);

      for (int i = 0; i < NQ; i++) if (q_rd_en[i]) pop_cnt[i]++;
      if (q_rd_en != '0) grant_cyc.push_back(cyc);
      if (out_vld && out_ready) begin
        acc_qid.push_back(int'(out_qid));
        acc_cyc.push_back(cyc);
        $display("xfer cyc=%0d qid=%0d len=%0d tuple=%0h count=%0d", cyc, out_qid, out_pkt_len, out_tuple, pkt_count);
      end
      rd_sample = q_rd_en;

      refill = (cyc % (int'(cfg_tick_div) + 1)) == int'(cfg_tick_div);
      if (refill) m_tokens = m_tokens + longint'(cfg_tokens_per_tick);
      if (exp_pop >= 0) m_tokens = m_tokens - longint'(head[LW-1:0]);
      if (m_tokens > longint'(cfg_bucket_max)) m_tokens = longint'(cfg_bucket_max);

      if (m_busy && out_ready) begin
        m_busy = 0;
        m_count++;
      end else if (exp_pop >= 0) begin
        m_busy = 1;
        {m_tuple, m_len} = head;
        m_qid = exp_pop;
        m_last = exp_pop;
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int exp_seq [8];
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    reset = 1'b1;
    out_ready = 1'b0;
    cfg_enable = 1'b1;
    // Generous bucket so the shaper (if built) never limits the unshaped scenarios.
    cfg_tick_div = 16'd0;
    cfg_tokens_per_tick = 24'd1000;
    cfg_bucket_max = 24'd100000;
    for (int i = 0; i < NQ; i++) pop_cnt[i] = 0;
    refresh();
    cyc_wait(3);
    reset = 1'b0;

    // Idle with all queues empty
    cyc_wait(100);
    chk("idle_vld", out_vld, 0);
    chk("idle_count", pkt_count, 0);
    chk("idle_pops", pop_cnt[0] + pop_cnt[1] + pop_cnt[2] + pop_cnt[3], 0);

    // Two entries per queue, back-to-back drain
    out_ready = 1'b1;
    acc_qid.delete();
    acc_cyc.delete();
    for (int e = 0; e < 2; e++)
      for (int q = 0; q < NQ; q++) push(q, TW'(32'h1000 + q*16 + e), LW'(64 + q));
    wait_acc(8, 100);
    for (int i = 0; i < 8; i++) if (i < acc_qid.size()) chk("rr_qid_seq", acc_qid[i], exp_seq[i]);
    for (int i = 1; i < 8; i++) if (i < acc_cyc.size()) chk("rr_gap", acc_cyc[i] - acc_cyc[i-1], 2);
    cyc_wait(2);
    chk("rr_count", pkt_count, 8);
    for (int q = 0; q < NQ; q++) chk("rr_pops", pop_cnt[q], 2);

    // Single queue with back-pressure
    out_ready = 1'b0;
    for (int i = 0; i < NQ; i++) pop_cnt[i] = 0;
    push(2, TW'(32'hABCDE), LW'(300));
    wait_vld(20);
    repeat (10) begin
      @(negedge clk);
      chk("hold_vld", out_vld, 1);
      chk("hold_desc", {out_tuple, out_pkt_len, out_qid}, {TW'(32'hABCDE), LW'(300), QW'(2)});
    end
    chk("hold_pops", pop_cnt[2], 1);
    cyc_wait(1);
    out_ready = 1'b1;
    cyc_wait(2);
    chk("hold_count", pkt_count, 9);
    chk("hold_done_vld", out_vld, 0);

    // cfg_enable dropped during SEND, then reset mid-SEND
    out_ready = 1'b0;
    for (int i = 0; i < NQ; i++) pop_cnt[i] = 0;
    push(1, TW'(32'h111), LW'(40));
    push(3, TW'(32'h333), LW'(41));
    wait_vld(10);
    chk("en_first_qid", out_qid, 3);
    cfg_enable = 1'b0;
    cyc_wait(1);
    out_ready = 1'b1;
    cyc_wait(20);
    chk("en_count", pkt_count, 10);
    chk("en_no_grant", pop_cnt[1], 0);
    chk("en_vld", out_vld, 0);
    out_ready = 1'b0;
    cfg_enable = 1'b1;
    wait_vld(10);
    chk("en_second_qid", out_qid, 1);
    push(0, TW'(32'h0A0), LW'(50));
    push(2, TW'(32'h2A2), LW'(52));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_vld", out_vld, 0);
    chk("rst_async_count", pkt_count, 0);
    chk("rst_async_tuple", out_tuple, 0);
    cyc_wait(2);
    reset = 1'b0;
    wait_vld(10);
    chk("rst_rr_qid", out_qid, 0);
    chk("rst_rr_len", out_pkt_len, 50);
    out_ready = 1'b1;
    cyc_wait(8);
    chk("rst_drain_count", pkt_count, 2);

`ifdef SCHED_SHAPER_EN
    // Shaped rate: 100 bytes per 10 cycles against 500-byte packets
    reset = 1'b1;
    cfg_tick_div = 16'd9;
    cfg_tokens_per_tick = 24'd100;
    cfg_bucket_max = 24'd1000;
    cyc_wait(2);
    for (int k = 0; k < 3; k++) push(0, TW'(32'h500 + k), LW'(500));
    grant_cyc.delete();
    reset = 1'b0;
    wait_grants(3, 250);
    if (grant_cyc.size() >= 3) begin
      chk("shp_grant0", grant_cyc[0], 50);
      chk("shp_grant1", grant_cyc[1], 100);
      chk("shp_grant2", grant_cyc[2], 150);
    end
    cyc_wait(5);

    // Exact-fit tokens with a refill landing on the grant cycle
    reset = 1'b1;
    cfg_bucket_max = 24'd100;
    cfg_enable = 1'b0;
    cyc_wait(2);
    for (int k = 0; k < 3; k++) push(0, TW'(32'h100 + k), LW'(100));
    grant_cyc.delete();
    reset = 1'b0;
    cyc_wait(19);
    cfg_enable = 1'b1;
    wait_grants(3, 60);
    if (grant_cyc.size() >= 3) begin
      chk("fit_grant0", grant_cyc[0], 19);
      chk("fit_grant1", grant_cyc[1], 21);
      chk("fit_grant2", grant_cyc[2], 30);
    end
    cyc_wait(5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tuple_dispatch_sched.md
# tuple_dispatch_sched

Round-robin scheduler that drains up to NUM_QUEUES tuple/length ingress FIFOs and hands one descriptor at a time to the packet generator over a valid/ready port. It sits between the per-flow ingress queues (fall-through FIFOs: `{tuple,len}` on dout while not empty, pop on rd_en) and the generator core. An optional token-bucket shaper limits the dispatched byte rate.

## Interface
- NUM_QUEUES, 4, number of ingress FIFOs (2..8); QW = $clog2(NUM_QUEUES)
- PKT_TUPLE_WIDTH, 104, five-tuple width
- PKT_LEN_WIDTH, 16, packet length width (bytes)
- TOKEN_WIDTH, 24, token bucket width (bytes)
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- q_data  in  NUM_QUEUES*(PKT_TUPLE_WIDTH+PKT_LEN_WIDTH)  FIFO heads; queue i at slice i, each `{tuple,len}` with len in the LSBs
- q_empty  in  NUM_QUEUES  FIFO empty flags
- q_rd_en  out  NUM_QUEUES  one-hot pop strobe, combinational
- out_tuple  out  PKT_TUPLE_WIDTH  descriptor tuple
- out_pkt_len  out  PKT_LEN_WIDTH  descriptor length
- out_qid  out  QW  source queue index
- out_vld  out  1  descriptor valid
- out_ready  in  1  generator accepts
- cfg_enable  in  1  permit new grants
- cfg_tick_div  in  16  refill period minus one, in cycles
- cfg_tokens_per_tick  in  TOKEN_WIDTH  bytes added per refill
- cfg_bucket_max  in  TOKEN_WIDTH  bucket ceiling
- pkt_count  out  32  descriptors accepted by generator, wraps

## Operation
- States: IDLE, SEND.
- IDLE: candidate = first queue with q_empty=0, searching from rr_ptr+1 modulo NUM_QUEUES. Grant when cfg_enable=1, candidate exists and candidate is eligible. On grant: q_rd_en[candidate]=1 for that cycle; head data, len and qid are registered into the output registers; rr_ptr <- candidate; go to SEND.
- SEND: out_vld=1, outputs held stable. On out_vld&out_ready: pkt_count+1, go to IDLE. No pop occurs in SEND.
- No skipping: an ineligible candidate (shaper) blocks the grant until it becomes eligible, which preserves RR fairness.
- cfg_enable=0: no new grant. A descriptor already in SEND still completes.
- pkt_len 0 is legal and consumes 0 tokens.
- Reset values: q_rd_en=0, out_vld=0, out_tuple=0, out_pkt_len=0, out_qid=0, pkt_count=0, rr_ptr=NUM_QUEUES-1 (so queue 0 is served first), tokens=0, tick counter=0, state IDLE.
- Reset in SEND: the popped descriptor is dropped.

## Timing
- Grant cycle N (q_rd_en high) -> out_vld high from cycle N+1.
- Peak throughput: one descriptor per 2 cycles, with out_ready held at 1.
- q_rd_en depends only on registered state, q_empty, q_data length field and tokens. It never depends on out_ready.
- Tick counter counts 0..cfg_tick_div and then wraps. Refill fires on the wrap cycle, i.e. every cfg_tick_div+1 cycles.

## Configuration
- Macro SCHED_SHAPER_EN defined:
  - eligible = tokens >= zero-extended head len.
  - Token update per cycle: tokens_next = min(tokens + (refill ? cfg_tokens_per_tick : 0) - (grant ? len : 0), cfg_bucket_max).
  - Compute the update at TOKEN_WIDTH+1 bits; it never underflows.
  - Simultaneous refill and grant both apply in the same cycle.
  - If cfg_bucket_max drops below tokens, tokens clamp on the next cycle.
  - Software keeps cfg_bucket_max >= largest pkt_len; otherwise the scheduler stalls.
- Macro undefined:
  - Token logic and tick counter are absent; every nonempty candidate is eligible.
  - cfg_tick_div, cfg_tokens_per_tick and cfg_bucket_max are ignored (ports remain).

## Test plan
- Reset, all queues empty, cfg_enable=1 -> outputs stay at reset values; q_rd_en=0 for 100 cycles.
- Queues 0–3 each hold 2 entries (lens 64, 65, 66, 67 per queue), out_ready=1, shaper off -> out_qid sequence 0,1,2,3,0,1,2,3; out_vld asserts every 2nd cycle; pkt_count=8; each queue popped exactly twice.
- Only queue 2 nonempty, out_ready low for 10 cycles after out_vld -> outputs held stable; exactly one q_rd_en pulse; accept on ready.
- Shaper on, cfg_tick_div=9, cfg_tokens_per_tick=100, cfg_bucket_max=1000, queue 0 holding lens of 500 -> first grant once tokens reach 500 (about cycle 50); the following grants about 50 cycles apart.
- Shaper on, tokens equal 100 exactly, head len 100, refill in the grant cycle -> grant occurs; tokens_next = tokens_per_tick.
- cfg_enable dropped in SEND, then reset asserted mid-SEND -> first: the in-flight descriptor completes and no further grant occurs; then on reset: out_vld=0 immediately, and rr_ptr/pkt_count return to reset values.
